// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with a two-flop input synchroniser, mid-bit sampling and a
// one-entry valid/ready holding register that reports framing errors and overruns.
module uart_rx_buf #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rxd,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_rxd_s;
    logic w_drain;
    logic w_can_load;
    logic w_cnt_mid;
    logic w_cnt_last;

    assign w_rxd_s    = r_sync2;
    assign w_drain    = r_valid & i_ready;
    assign w_can_load = ~r_valid | w_drain;
    assign w_cnt_mid  = (r_clk_cnt == CNT_MID);
    assign w_cnt_last = (r_clk_cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM, shift register and registered handshake/status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            // A delivery later in this block overrides the drain clear.
            if (w_drain) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (!w_rxd_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_cnt_mid) begin
                        r_clk_cnt <= '0;
                        if (!w_rxd_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_cnt_last) begin
                        r_clk_cnt          <= '0;
                        r_shift[r_bit_idx] <= w_rxd_s;
                        if (r_bit_idx == BIT_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_ONE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (w_cnt_last) begin
                        r_clk_cnt <= '0;
                        if (w_rxd_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (w_can_load) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_state     <= S_BREAK;
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                // A line held low reports one framing error, then waits for idle.
                S_BREAK: begin
                    r_clk_cnt <= '0;
                    if (w_rxd_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_busy      = r_busy;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule
